// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, encodings and MEM-stage FSM states
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;
endpackage

// File: rtl/mem_stage_ctrl_wait_timer.sv
// rtl/mem_stage_ctrl_wait_timer.sv - saturating WAIT-cycle counter with expiry flag
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign expired_o = (count_q == TW'(TIMEOUT_CYCLES - 1));

  // Holds at the expiry value so the count can never wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (en_i && !expired_o)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage sequencer for a multi-cycle req/ack data bus
module mem_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            FlushW,
  output logic            MemErrM
);
  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            timer_clr, timer_en, timer_expired;
  logic            acc, misaligned;

  assign acc        = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
  assign misaligned = (ALUResultM[1:0] != 2'b00);

  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Ack takes priority over expiry so a late-but-valid response is never discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc) state_d = misaligned ? ERR : WAIT;
      WAIT: begin
        if (mem_ack)
          state_d = DONE;
        else if (timer_expired)
          state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    StallM = ((state_q == IDLE) && acc) || (state_q == WAIT);
    FlushW = StallM;
  end

  always_comb begin
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && !misaligned) begin
          req_d     = 1'b1;
          we_d      = MemWriteM;
          addr_d    = {ALUResultM[XLEN-1:2], 2'b00};
          wdata_d   = WriteDataM;
          timer_clr = 1'b1;
        end else if (acc && !MemWriteM) begin
          rdata_d = ERR_RDATA;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (!we_q)
            rdata_d = mem_rdata;
        end else if (timer_expired) begin
          req_d   = 1'b0;
          rdata_d = ERR_RDATA;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: ;
    endcase
    err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign MemErrM   = err_q;
endmodule
